// File: rtl/bandpass_filter_avalon_st_if.sv
// Avalon-ST beat bundle shared by the filter sink and source.
// master drives the beat, slave returns ready.
interface bandpass_filter_avalon_st_if #(
    parameter int WIDTH = 8
);
    logic             ready;
    logic             valid;
    logic             startofpacket;
    logic             endofpacket;
    logic [WIDTH-1:0] data;

    modport master (
        input  ready,
        output valid, startofpacket, endofpacket, data
    );

    modport slave (
        output ready,
        input  valid, startofpacket, endofpacket, data
    );
endinterface

// File: rtl/bandpass_filter_avalon_st.sv
// Value-window band-pass filter on an Avalon-ST stream.
// CSR cutoffs and modes, saturating drop counter, registered output FIFO.
module bandpass_filter_avalon_st #(
    parameter int                  IN_WIDTH      = 8,
    parameter int                  OUT_WIDTH     = 8,
    parameter int                  FIFO_DEPTH    = 4,
    parameter int                  COUNT_WIDTH   = 16,
    parameter logic [IN_WIDTH-1:0] DEFAULT_LOW   = '0,
    parameter logic [IN_WIDTH-1:0] DEFAULT_HIGH  = '1,
    parameter logic [1:0]          DEFAULT_CTRL  = 2'b00,
    parameter logic [IN_WIDTH-1:0] NEW_EOP_VALUE = '0
) (
    input  logic        clock,
    input  logic        reset,
    bandpass_filter_avalon_st_if.slave  in_st,
    bandpass_filter_avalon_st_if.master out_st,
    input  logic [1:0]  csr_address,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    input  logic        csr_read,
    output logic [31:0] csr_readdata,
    output logic        wait_for_eop
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = IN_WIDTH + 2;
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {PASS, DISCARD} state_t;

    state_t state, state_nx;

    logic [IN_WIDTH-1:0]    low_q, high_q;
    logic [1:0]             ctrl_q;
    logic [COUNT_WIDTH-1:0] drop_q;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic          accept, pop, is_delim, in_win;
    logic          push, drop_inc, cnt_clr;
    logic [EW-1:0] push_word, head;
    logic          unused_wd;

    assign unused_wd = ^csr_writedata;

    assign in_st.ready = (count < FULL);
    assign accept      = in_st.valid & in_st.ready;
    assign out_st.valid = (count != '0);
    assign pop         = out_st.valid & out_st.ready;

    assign is_delim = in_st.startofpacket | in_st.endofpacket;
    assign in_win   = (in_st.data >= low_q) && (in_st.data <= high_q);
    assign cnt_clr  = csr_write && (csr_address == 2'd3);

    assign wait_for_eop = (state == DISCARD);

    // Filter state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= PASS;
        else       state <= state_nx;
    end

    // Enter DISCARD on an exceeding beat, leave on any accepted eop.
    always_comb begin
        state_nx = state;
        if (accept) begin
            unique case (state)
                PASS: begin
                    if (!is_delim && !in_win && ctrl_q[1])
                        state_nx = DISCARD;
                end
                DISCARD: begin
                    if (in_st.endofpacket)
                        state_nx = PASS;
                end
            endcase
        end
    end

    // Decide what an accepted beat pushes and whether it counts as a drop.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        drop_inc  = 1'b0;
        if (accept && state == PASS) begin
            if (is_delim) begin
                push      = ctrl_q[0];
                push_word = {in_st.endofpacket, in_st.startofpacket,
                             in_st.data};
            end else if (in_win) begin
                push      = 1'b1;
                push_word = {2'b00, in_st.data};
            end else begin
                drop_inc = 1'b1;
                if (ctrl_q[1]) begin
                    push      = 1'b1;
                    push_word = {2'b10, NEW_EOP_VALUE};
                end
            end
        end
    end

    // Cutoff and mode registers; writes land at the next edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            low_q  <= DEFAULT_LOW;
            high_q <= DEFAULT_HIGH;
            ctrl_q <= DEFAULT_CTRL;
        end else if (csr_write) begin
            unique case (csr_address)
                2'd0:    low_q  <= csr_writedata[IN_WIDTH-1:0];
                2'd1:    high_q <= csr_writedata[IN_WIDTH-1:0];
                2'd2:    ctrl_q <= csr_writedata[1:0];
                default: ;
            endcase
        end
    end

    // Saturating drop counter; a clearing write beats a same-cycle drop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            drop_q <= '0;
        else if (cnt_clr)
            drop_q <= '0;
        else if (drop_inc && drop_q != '1)
            drop_q <= drop_q + 1'b1;
    end

    // Combinational register readback, zero when not reading.
    always_comb begin
        csr_readdata = '0;
        if (csr_read) begin
            unique case (csr_address)
                2'd0: csr_readdata = 32'(low_q);
                2'd1: csr_readdata = 32'(high_q);
                2'd2: csr_readdata = 32'(ctrl_q);
                2'd3: csr_readdata = 32'(drop_q);
            endcase
        end
    end

    // FIFO storage; visibility is gated by count, so no reset needed.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    // FIFO pointers and occupancy; reset flushes queued beats.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    assign head = mem[rd_ptr];

    // Source outputs are forced to zero while the FIFO is empty.
    always_comb begin
        out_st.data          = '0;
        out_st.startofpacket = 1'b0;
        out_st.endofpacket   = 1'b0;
        if (out_st.valid) begin
            out_st.data          = OUT_WIDTH'(head[IN_WIDTH-1:0]);
            out_st.startofpacket = head[IN_WIDTH];
            out_st.endofpacket   = head[IN_WIDTH+1];
        end
    end
endmodule
